// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types and command/response codes.
// Imported by the host transmitter and the keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
   localparam logic [7:0] PS2_BREAK       = 8'hF0;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command request handshake and status to the PS/2
// host transmitter.
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  busy,
      input  done,
      input  error
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output busy,
      output done,
      output error
   );

endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronisers for the PS/2 pins plus
// falling-edge detect on the clock line.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_s,
   output logic dat_s,
   output logic clk_fall
);

   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       clk_hist;

   // Reset to the idle-high bus level so release never looks like a fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_hist <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk_i};
         dat_sync <= {dat_sync[0], ps2_dat_i};
         clk_hist <= clk_sync[1];
      end
   end

   assign clk_s    = clk_sync[1];
   assign dat_s    = dat_sync[1];
   assign clk_fall = clk_hist & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device command transmitter.
// Define PS2_TX_RETRY_EN to retry failed frames up to MAX_RETRY times.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
`ifdef PS2_TX_RETRY_EN
   ,
   parameter int MAX_RETRY = 2
`endif
) (
   input  logic          clk,
   input  logic          reset,
   ps2_host_tx_if.slave  bus,
   input  logic          ps2_clk_i,
   input  logic          ps2_dat_i,
   output logic          ps2_clk_oe,
   output logic          ps2_dat_oe
);

   localparam int CW = $clog2(INHIBIT_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - 2);
   localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   ps2_state_e    state;
   logic [7:0]    shreg;
   logic          parity;
   logic [CW-1:0] inh_cnt;
   logic [3:0]    bitcnt;
   logic [TW-1:0] tmo_cnt;
   logic          done_r;
   logic          error_r;
`ifdef PS2_TX_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0] retry_cnt;
`endif

   logic clk_s;
   logic dat_s;
   logic clk_fall;
   logic nak;
   logic tmo_hit;

   ps2_sync_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk_i (ps2_clk_i),
      .ps2_dat_i (ps2_dat_i),
      .clk_s     (clk_s),
      .dat_s     (dat_s),
      .clk_fall  (clk_fall)
   );

   assign nak     = (state == ACK) && clk_fall && dat_s;
   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         parity     <= 1'b0;
         inh_cnt    <= '0;
         bitcnt     <= '0;
         tmo_cnt    <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_cnt  <= '0;
`endif
      end else begin
         done_r  <= 1'b0;
         error_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.tx_valid) begin
                  shreg      <= bus.tx_data;
                  parity     <= odd_parity(bus.tx_data);
                  inh_cnt    <= '0;
                  ps2_clk_oe <= 1'b1;
                  state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                  retry_cnt  <= '0;
`endif
               end
            end
            INHIBIT: begin
               inh_cnt <= inh_cnt + 1'b1;
               // Start bit goes low while the clock is still held.
               if (inh_cnt == INH_START)
                  ps2_dat_oe <= 1'b1;
               if (inh_cnt == INH_LAST) begin
                  ps2_clk_oe <= 1'b0;
                  bitcnt     <= '0;
                  tmo_cnt    <= '0;
                  state      <= SEND;
               end
            end
            SEND, ACK, WAIT_IDLE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (nak || tmo_hit) begin
                  ps2_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     retry_cnt  <= retry_cnt + 1'b1;
                     inh_cnt    <= '0;
                     ps2_clk_oe <= 1'b1;
                     state      <= INHIBIT;
                  end else begin
                     ps2_clk_oe <= 1'b0;
                     error_r    <= 1'b1;
                     state      <= IDLE;
                  end
`else
                  ps2_clk_oe <= 1'b0;
                  error_r    <= 1'b1;
                  state      <= IDLE;
`endif
               end else if (state == SEND && clk_fall) begin
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt < 4'd8) begin
                     ps2_dat_oe <= ~shreg[bitcnt[2:0]];
                  end else if (bitcnt == 4'd8) begin
                     ps2_dat_oe <= ~parity;
                  end else begin
                     ps2_dat_oe <= 1'b0;
                     state      <= ACK;
                  end
               end else if (state == ACK && clk_fall) begin
                  state <= WAIT_IDLE;
               end else if (state == WAIT_IDLE && clk_s && dat_s) begin
                  done_r <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_r;
   assign bus.error    = error_r;

endmodule
